// File: rtl/bool_func_sweeper_pkg.sv
// Shared types and constants for the boolean function sweeper.
package bfs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  // AB' + C'(A+B) with A=bit0, B=bit1, C=bit2
  localparam logic [7:0] DEFAULT_TT_3IN = 8'h2E;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/bool_func_sweeper_sweep_step_timer.sv
// Hold counter for one sweep vector: counts 0..STEP_CYC-1 and flags the last cycle.
module sweep_step_timer
  import bfs_pkg::*;
#(
  parameter int STEP_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last_cycle
);

  localparam int CW = clog2(STEP_CYC);
  localparam logic [CW-1:0] LAST = CW'(STEP_CYC - 1);

  logic [CW-1:0] cnt;

  assign last_cycle = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/bool_func_sweeper.sv
// Programmable N-input truth table with a live registered output and an
// exhaustive sweep engine that captures the table and its ones count.
module bool_func_sweeper
  import bfs_pkg::*;
#(
  parameter int                        N_IN     = 3,
  parameter int                        STEP_CYC = 4,
  parameter logic [(1 << N_IN) - 1:0]  RESET_TT = DEFAULT_TT_3IN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_IN-1:0]            in_vec,
  output logic                       out,
  input  logic                       cfg_load,
  input  logic [(1 << N_IN) - 1:0]   cfg_tt,
  input  logic                       start,
  output logic                       busy,
  output logic [N_IN-1:0]            sweep_vec,
  output logic                       sweep_out,
  output logic                       sweep_valid,
  output logic                       done,
  output logic [(1 << N_IN) - 1:0]   result_tt,
  output logic [N_IN:0]              ones_cnt
);

  localparam int TT_W = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(TT_W - 1);

  state_t            state;
  logic [TT_W-1:0]   tt;
  logic [TT_W-1:0]   scratch;
  logic [N_IN:0]     count;
  logic              last_cycle;
  logic              cur_bit;

  assign cur_bit = tt[sweep_vec];

  sweep_step_timer #(
    .STEP_CYC (STEP_CYC)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr        (state != SWEEP),
    .en         (state == SWEEP),
    .last_cycle (last_cycle)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tt          <= RESET_TT;
      out         <= 1'b0;
      busy        <= 1'b0;
      sweep_vec   <= '0;
      sweep_out   <= 1'b0;
      sweep_valid <= 1'b0;
      done        <= 1'b0;
      result_tt   <= '0;
      ones_cnt    <= '0;
      scratch     <= '0;
      count       <= '0;
    end else begin
      // Live path reads the table before any same-cycle load takes effect.
      out         <= tt[in_vec];
      sweep_valid <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_load) tt <= cfg_tt;
          if (start) begin
            state     <= SWEEP;
            busy      <= 1'b1;
            sweep_vec <= '0;
            scratch   <= '0;
            count     <= '0;
          end
        end
        SWEEP: begin
          if (last_cycle) begin
            sweep_valid        <= 1'b1;
            sweep_out          <= cur_bit;
            scratch[sweep_vec] <= cur_bit;
            count              <= count + (N_IN + 1)'(cur_bit);
            // Terminal vector is detected explicitly, so sweep_vec never wraps.
            if (sweep_vec == LAST_VEC) begin
              state <= DONE;
              busy  <= 1'b0;
            end else begin
              sweep_vec <= sweep_vec + N_IN'(1);
            end
          end
        end
        DONE: begin
          done      <= 1'b1;
          result_tt <= scratch;
          ones_cnt  <= count;
          sweep_vec <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bool_func_sweeper.sv
// Directed + randomized bench for bool_func_sweeper (3-input default and 4-input parity build).
module tb_bool_func_sweeper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [2:0]  in_vec = '0;
  logic        out;
  logic        cfg_load = 1'b0;
  logic [7:0]  cfg_tt = '0;
  logic        start = 1'b0;
  logic        busy;
  logic [2:0]  sweep_vec;
  logic        sweep_out;
  logic        sweep_valid;
  logic        done;
  logic [7:0]  result_tt;
  logic [3:0]  ones_cnt;

  logic [3:0]  in_vec4 = '0;
  logic        out4;
  logic        cfg_load4 = 1'b0;
  logic [15:0] cfg_tt4 = '0;
  logic        start4 = 1'b0;
  logic        busy4;
  logic [3:0]  sweep_vec4;
  logic        sweep_out4;
  logic        sweep_valid4;
  logic        done4;
  logic [15:0] result_tt4;
  logic [4:0]  ones_cnt4;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [7:0] model_tt;
  logic [7:0] golden_tt;

  always #5 clk = ~clk;

  bool_func_sweeper dut (
    .clk(clk), .rst(rst), .in_vec(in_vec), .out(out), .cfg_load(cfg_load),
    .cfg_tt(cfg_tt), .start(start), .busy(busy), .sweep_vec(sweep_vec),
    .sweep_out(sweep_out), .sweep_valid(sweep_valid), .done(done),
    .result_tt(result_tt), .ones_cnt(ones_cnt)
  );

  bool_func_sweeper #(.N_IN(4), .STEP_CYC(1), .RESET_TT(16'h00FF)) dut4 (
    .clk(clk), .rst(rst), .in_vec(in_vec4), .out(out4), .cfg_load(cfg_load4),
    .cfg_tt(cfg_tt4), .start(start4), .busy(busy4), .sweep_vec(sweep_vec4),
    .sweep_out(sweep_out4), .sweep_valid(sweep_valid4), .done(done4),
    .result_tt(result_tt4), .ones_cnt(ones_cnt4)
  );

  function automatic int popcount(input logic [31:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) c += int'(v[i]);
    return c;
  endfunction

  // Default function AB' + C'(A+B) evaluated from its boolean definition.
  function automatic logic [7:0] default_table();
    logic [7:0] t;
    logic a, b, c;
    for (int v = 0; v < 8; v++) begin
      a = v[0]; b = v[1]; c = v[2];
      t[v] = (a & ~b) | (~c & (a | b));
    end
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic live_check(input string tag, input int n);
    int bad;
    logic [2:0] v;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      v = 3'($urandom_range(0, 7));
      in_vec = v;
      tick();
      if (out !== model_tt[v]) bad++;
    end
    check(tag, bad, 0);
  endtask

  // Starts a sweep on the 3-input unit and checks the whole pulse pattern.
  task automatic sweep3(input string tag, input bit with_load, input logic [7:0] load_tt,
                        input bit disturb);
    int bad, dones, done_at;
    bit exp_valid;
    bad = 0; dones = 0; done_at = -1;
    if (with_load) begin
      cfg_load = 1'b1;
      cfg_tt   = load_tt;
      model_tt = load_tt;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_load = 1'b0;
    for (int cyc = 0; cyc <= 36; cyc++) begin
      if (cyc > 0) tick();
      if (disturb && cyc == 10) begin
        cfg_load = 1'b1; cfg_tt = 8'h81; start = 1'b1;
      end else if (disturb && cyc == 11) begin
        cfg_load = 1'b0; start = 1'b0;
      end
      exp_valid = (cyc >= 4) && (cyc % 4 == 0) && (cyc <= 32);
      if (busy !== (cyc < 32)) bad++;
      if (sweep_valid !== exp_valid) bad++;
      if (exp_valid) begin
        if (sweep_out !== model_tt[cyc / 4 - 1]) bad++;
      end
      if (done === 1'b1) begin
        dones++;
        done_at = cyc;
      end
    end
    check({tag, "_pattern"}, bad, 0);
    check({tag, "_done_cnt"}, dones, 1);
    check({tag, "_done_at"}, done_at, 33);
    check({tag, "_result"}, result_tt, model_tt);
    check({tag, "_ones"}, ones_cnt, popcount(model_tt));
  endtask

  initial begin
    int bad, dones, run;
    logic [7:0]  rnd;
    logic [15:0] parity_tt;
    bit          exp_valid;

    golden_tt = default_table();
    model_tt  = golden_tt;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_out", out, 0);
    check("rst_busy", busy, 0);
    check("rst_sweep_vec", sweep_vec, 0);
    check("rst_sweep_valid", sweep_valid, 0);
    check("rst_done", done, 0);
    check("rst_result", result_tt, 0);
    check("rst_ones", ones_cnt, 0);

    // Live path over every input with the reset table
    for (int v = 0; v < 8; v++) begin
      in_vec = 3'(v);
      tick();
      check($sformatf("live_in%0d", v), out, golden_tt[v]);
    end

    // Default-table sweep
    sweep3("sweep_default", 1'b0, 8'h00, 1'b0);

    // All-ones and all-zeros tables, load then start on the next cycle
    cfg_load = 1'b1; cfg_tt = 8'hFF; model_tt = 8'hFF;
    tick();
    cfg_load = 1'b0;
    sweep3("sweep_ff", 1'b0, 8'h00, 1'b0);
    check("ones_ff_no_wrap", ones_cnt, 8);
    sweep3("sweep_00", 1'b1, 8'h00, 1'b0);
    check("ones_00", ones_cnt, 0);

    // Random tables loaded in the same cycle as start, plus live evaluation
    for (int k = 0; k < 3; k++) begin
      rnd = 8'($urandom);
      sweep3($sformatf("sweep_rand%0d", k), 1'b1, rnd, 1'b0);
      live_check($sformatf("live_rand%0d", k), 12);
    end

    // cfg_load and start during a sweep are ignored
    sweep3("sweep_disturb", 1'b1, golden_tt, 1'b1);
    in_vec = 3'd0;
    tick();
    check("no_late_load", out, 0);
    live_check("live_after_disturb", 10);

    // Reset in the middle of vector 5 aborts the sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 22; cyc++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_tt = golden_tt;
    check("abort_busy", busy, 0);
    check("abort_result", result_tt, 0);
    check("abort_ones", ones_cnt, 0);
    dones = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    check("abort_no_done", dones, 0);
    live_check("live_reset_table", 10);
    sweep3("sweep_after_abort", 1'b0, 8'h00, 1'b0);

    // 4-input parity build with single-cycle hold
    for (int v = 0; v < 16; v++) parity_tt[v] = ^(4'(v));
    cfg_load4 = 1'b1; cfg_tt4 = parity_tt;
    tick();
    cfg_load4 = 1'b0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    bad = 0; dones = 0; run = 0;
    for (int cyc = 0; cyc <= 20; cyc++) begin
      if (cyc > 0) tick();
      exp_valid = (cyc >= 1) && (cyc <= 16);
      if (busy4 !== (cyc < 16)) bad++;
      if (sweep_valid4 !== exp_valid) bad++;
      if (exp_valid) begin
        if (sweep_out4 !== parity_tt[cyc - 1]) bad++;
      end
      if (sweep_valid4 === 1'b1) run++;
      if (done4 === 1'b1) begin
        dones++;
        if (cyc != 17) bad++;
      end
    end
    check("p4_pattern", bad, 0);
    check("p4_valid_run", run, 16);
    check("p4_done_cnt", dones, 1);
    check("p4_result", result_tt4, 16'h6996);
    check("p4_ones", ones_cnt4, 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
